// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM. Port 0 is a read-only video
// fetch and port 1 is a CPU read/write port. Ties alternate between the ports,
// each access holds its strobes for ACCESS_CYCLES clocks and then spends one
// DONE cycle that pulses the ack. All SRAM pins come straight from flops.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [19:0] p0_addr,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [19:0] p1_addr,
  input  logic [1:0]  p1_be,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic [19:0] sram_ADDR,
  inout  wire  [15:0] sram_DQ,
  output logic        sram_CE_N,
  output logic        sram_OE_N,
  output logic        sram_WE_N,
  output logic        sram_LB_N,
  output logic        sram_UB_N,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic [15:0] p0_rdata_q, p0_rdata_d;
  logic [15:0] p1_rdata_q, p1_rdata_d;
  logic [19:0] addr_q, addr_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        grant_port;

  // Next-state, grant decision and next values of every registered SRAM pin.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    addr_d       = addr_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    lb_n_d       = lb_n_q;
    ub_n_d       = ub_n_q;
    dq_oe_d      = dq_oe_q;
    dq_out_d     = dq_out_q;
    // On a tie the port that did not win last time gets the bus.
    grant_port   = (p0_req && p1_req) ? ~last_grant_q : p1_req;

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d      = ACCESS;
          cnt_d        = CNT_LOAD;
          port_d       = grant_port;
          last_grant_d = grant_port;
          we_d         = grant_port & p1_we;
          addr_d       = grant_port ? p1_addr : p0_addr;
          ce_n_d       = 1'b0;
          oe_n_d       = we_d;
          we_n_d       = ~we_d;
          lb_n_d       = we_d ? ~p1_be[0] : 1'b0;
          ub_n_d       = we_d ? ~p1_be[1] : 1'b0;
          dq_oe_d      = we_d;
          dq_out_d     = p1_wdata;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (port_q) p1_ack_d = 1'b1;
          else        p0_ack_d = 1'b1;
          if (we_q) begin
            // Release WE but keep chip select and data for hold time.
            we_n_d = 1'b1;
            oe_n_d = 1'b1;
          end else begin
            if (port_q) p1_rdata_d = sram_DQ;
            else        p0_rdata_d = sram_DQ;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            dq_oe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and SRAM pins; reset aborts any access without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= 16'h0000;
      p1_rdata_q   <= 16'h0000;
      addr_q       <= 20'h00000;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      addr_q       <= addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      lb_n_q       <= lb_n_d;
      ub_n_q       <= ub_n_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  // Write data register; only visible on the pins while dq_oe_q is set.
  always_ff @(posedge clk) begin
    dq_out_q <= dq_out_d;
  end

  assign sram_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign sram_ADDR = addr_q;
  assign sram_CE_N = ce_n_q;
  assign sram_OE_N = oe_n_q;
  assign sram_WE_N = we_n_q;
  assign sram_LB_N = lb_n_q;
  assign sram_UB_N = ub_n_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (ACCESS_CYCLES = 2, 1, 15), each with
// a small SRAM chip model, scripted then random requesters, and a
// transaction-level reference that predicts grant order, pin values, ack
// timing and read data from grant times and plain arithmetic.
module tb_sram_arbiter;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int AC = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

    logic        reset;
    logic        p0_req;
    logic [19:0] p0_addr;
    logic        p0_ack;
    logic [15:0] p0_rdata;
    logic        p1_req;
    logic        p1_we;
    logic [19:0] p1_addr;
    logic [1:0]  p1_be;
    logic [15:0] p1_wdata;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n, busy;
    bit          fin = 1'b0;
    bit          preload = 1'b1;

    logic [15:0] chip [64];

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be),
      .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .sram_ADDR(sram_addr), .sram_DQ(sram_dq), .sram_CE_N(ce_n), .sram_OE_N(oe_n),
      .sram_WE_N(we_n), .sram_LB_N(lb_n), .sram_UB_N(ub_n), .busy(busy)
    );

    // SRAM chip: drives DQ on a read strobe, stores enabled bytes on a write strobe.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? chip[sram_addr[5:0]] : 16'hzzzz;

    always @(negedge clk) begin
      if (preload) begin
        for (int i = 0; i < 64; i++) chip[i] = init_word(i);
      end else if (!ce_n && !we_n) begin
        if (!lb_n) chip[sram_addr[5:0]][7:0]  = sram_dq[7:0];
        if (!ub_n) chip[sram_addr[5:0]][15:8] = sram_dq[15:8];
      end
    end

    // Reference state
    logic [15:0] ref_mem [64];
    logic [15:0] exp_rd [2];
    int          free_at, g;
    bit          act_valid, act_port, act_we, last_port;
    logic [1:0]  act_be;
    logic [19:0] act_addr;
    logic [15:0] act_wdata;
    bit          pend0, pend1, ack1_seen;
    req_t        scr0[$];
    req_t        scr1[$];
    int          n;

    task automatic model_edge(input int e);
      if (act_valid && !act_we && e == g + AC) exp_rd[act_port] = ref_mem[act_addr[5:0]];
      if (e >= free_at && (p0_req || p1_req)) begin
        act_port  = (p0_req && p1_req) ? !last_port : p1_req;
        act_we    = act_port ? p1_we : 1'b0;
        act_addr  = act_port ? p1_addr : p0_addr;
        act_be    = p1_be;
        act_wdata = p1_wdata;
        act_valid = 1'b1;
        last_port = act_port;
        g         = e;
        free_at   = e + AC + 2;
        if (act_we) begin
          if (act_be[0]) ref_mem[act_addr[5:0]][7:0]  = act_wdata[7:0];
          if (act_be[1]) ref_mem[act_addr[5:0]][15:8] = act_wdata[15:8];
        end
      end
    endtask

    task automatic check_period(input int e);
      logic [7:0] exp_pins, mask, obs_pins;
      bit in_acc, in_done;
      in_acc   = act_valid && e >= g && e < g + AC;
      in_done  = act_valid && e == g + AC;
      obs_pins = {busy, p0_ack, p1_ack, ce_n, oe_n, we_n, lb_n, ub_n};
      exp_pins = 8'b000_11111;
      mask     = 8'b1111_1100;
      if (in_acc) begin
        mask     = 8'hFF;
        exp_pins = {3'b100, 1'b0, act_we, !act_we,
                    act_we ? !act_be[0] : 1'b0, act_we ? !act_be[1] : 1'b0};
        chk($sformatf("ac%0d_addr n=%0d", AC, e), sram_addr, act_addr);
      end else if (in_done) begin
        mask     = 8'hFF;
        exp_pins = act_we ? {1'b1, !act_port, act_port, 3'b011, !act_be[0], !act_be[1]}
                          : {1'b1, !act_port, act_port, 5'b11111};
      end
      chk($sformatf("ac%0d_pins n=%0d", AC, e), obs_pins & mask, exp_pins & mask);
      if ((in_acc || in_done) && act_we)
        chk($sformatf("ac%0d_dq n=%0d", AC, e), sram_dq, act_wdata);
      chk($sformatf("ac%0d_rd0 n=%0d", AC, e), p0_rdata, exp_rd[0]);
      chk($sformatf("ac%0d_rd1 n=%0d", AC, e), p1_rdata, exp_rd[1]);
    endtask

    task automatic drive(input bit allow_new);
      req_t r;
      if (pend0 && p0_ack) pend0 = 1'b0;
      if (pend1 && p1_ack) begin
        pend1     = 1'b0;
        ack1_seen = 1'b1;
      end
      if (!pend0) begin
        if (scr0.size() > 0) begin
          r = scr0.pop_front();
          pend0 = 1'b1;
          p0_addr = r.addr;
        end else if (allow_new && $urandom_range(0, 2) != 0) begin
          pend0 = 1'b1;
          p0_addr = 20'($urandom);
        end
      end
      if (!pend1) begin
        if (scr1.size() > 0) begin
          r = scr1.pop_front();
          pend1 = 1'b1;
          p1_we = r.we; p1_addr = r.addr; p1_be = r.be; p1_wdata = r.wdata;
        end else if (allow_new && $urandom_range(0, 2) != 0) begin
          pend1 = 1'b1;
          p1_we = 1'($urandom); p1_addr = 20'($urandom);
          p1_be = 2'($urandom); p1_wdata = 16'($urandom);
        end
      end
      p0_req = pend0;
      p1_req = pend1;
    endtask

    task automatic step(input bit allow_new);
      model_edge(n);
      @(posedge clk);
      #1;
      check_period(n);
      drive(allow_new);
      n++;
    endtask

    initial begin
      reset = 1'b0;
      p0_req = 1'b0; p0_addr = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      free_at = 0; g = 0; act_valid = 1'b0; last_port = 1'b1;
      pend0 = 1'b0; pend1 = 1'b0; ack1_seen = 1'b0; n = 0;
      act_port = 1'b0; act_we = 1'b0; act_be = '0; act_addr = '0; act_wdata = '0;
      #1 reset = 1'b1;
      #1;
      chk($sformatf("ac%0d_rst_pins", AC), {busy, p0_ack, p1_ack, ce_n, oe_n, we_n, lb_n, ub_n}, 8'b000_11111);
      chk($sformatf("ac%0d_rst_addr", AC), sram_addr, 20'h0);
      chk($sformatf("ac%0d_rst_rd0", AC), p0_rdata, 16'h0);
      chk($sformatf("ac%0d_rst_rd1", AC), p1_rdata, 16'h0);
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      reset   = 1'b0;

      // Both ports raised together and held: p0 first, then alternating.
      scr0.push_back(req_t'{1'b0, 20'h00010, 2'b11, 16'h0000});
      scr0.push_back(req_t'{1'b0, 20'h00020, 2'b11, 16'h0000});
      scr0.push_back(req_t'{1'b0, 20'h00010, 2'b11, 16'h0000});
      scr1.push_back(req_t'{1'b1, 20'hFFFFF, 2'b10, 16'h1234});
      scr1.push_back(req_t'{1'b0, 20'hFFFFF, 2'b11, 16'h0000});
      scr1.push_back(req_t'{1'b1, 20'h00005, 2'b00, 16'hAAAA});
      scr1.push_back(req_t'{1'b0, 20'h00005, 2'b11, 16'h0000});
      drive(1'b1);

      repeat (300) step(1'b1);
      repeat (2 * AC + 6) step(1'b0);

      // Reset in the first ACCESS cycle of a p1 write.
      pend1 = 1'b1; p1_we = 1'b1; p1_addr = 20'hABC07; p1_be = 2'b11; p1_wdata = 16'hC3C3;
      p1_req = 1'b1; ack1_seen = 1'b0;
      model_edge(n);
      @(posedge clk);
      #1;
      check_period(n);
      n++;
      #2 reset = 1'b1;
      #1;
      chk($sformatf("ac%0d_abort_pins", AC), {busy, p0_ack, p1_ack, ce_n, oe_n, we_n, lb_n, ub_n}, 8'b000_11111);
      chk($sformatf("ac%0d_abort_addr", AC), sram_addr, 20'h0);
      chk($sformatf("ac%0d_abort_rd0", AC), p0_rdata, 16'h0);
      chk($sformatf("ac%0d_abort_rd1", AC), p1_rdata, 16'h0);
      @(posedge clk);
      #1;
      chk($sformatf("ac%0d_abort_ack", AC), {busy, p1_ack}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      act_valid = 1'b0; free_at = n; last_port = 1'b1;
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      repeat (AC + 4) step(1'b0);
      chk($sformatf("ac%0d_reissue_ack", AC), ack1_seen, 1'b1);
      chk($sformatf("ac%0d_reissue_mem", AC), chip[7], 16'hC3C3);
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
      @(posedge clk);
    end
    chk("all_done", {g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}, 3'b111);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, SRAM access strobe length in clocks (legal 1..15).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports p0_req in 1, p0_addr in 20: requester 0 (video fetch), read-only word request.
REQ-005 SHALL have ports p0_ack out 1, p0_rdata out 16: single-cycle completion pulse and read data.
REQ-006 SHALL have ports p1_req in 1, p1_we in 1, p1_addr in 20, p1_be in 2, p1_wdata in 16: requester 1 (CPU) read/write, be[0]=low byte, be[1]=high byte.
REQ-007 SHALL have ports p1_ack out 1, p1_rdata out 16: completion pulse and read data.
REQ-008 SHALL have ports sram_ADDR out 20, sram_DQ inout 16, sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N out 1 each: async SRAM pins, active-low strobes.
REQ-009 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, DONE; all SRAM pin outputs registered.
REQ-011 Requester SHALL hold req and request fields stable until its ack; ack SHALL be exactly one cycle; req still high after ack = new request.
REQ-012 In IDLE with exactly one req high SHALL grant that port; both high SHALL grant the port not granted last (last_grant resets to 1, so port 0 wins first tie).
REQ-013 On grant SHALL latch addr, we (0 for port 0), be, wdata, port id; load counter ACCESS_CYCLES-1; go ACCESS next cycle.
REQ-014 ACCESS read: CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ released, ADDR=latched addr.
REQ-015 ACCESS write: CE_N=0, OE_N=1, WE_N=0, LB_N=~be[0], UB_N=~be[1], DQ driven with latched wdata.
REQ-016 ACCESS SHALL last exactly ACCESS_CYCLES cycles (counter decrements to 0), then DONE.
REQ-017 Read: on edge leaving last ACCESS cycle SHALL capture sram_DQ into granted port's rdata; other port's rdata unchanged.
REQ-018 DONE SHALL assert granted port's ack for one cycle, then IDLE.
REQ-019 DONE read: all strobes high, DQ released; DONE write: CE_N=0, WE_N=1, OE_N=1, DQ still driven (data hold), byte strobes unchanged.
REQ-020 Latency: req sampled in IDLE at edge k -> ACCESS cycles k+1..k+ACCESS_CYCLES -> ack cycle k+ACCESS_CYCLES+1; one access per ACCESS_CYCLES+2 cycles max.
REQ-021 Write with p1_be=00 SHALL run full cycle with LB_N=UB_N=1 and ack normally.
REQ-022 req changes while not IDLE SHALL be ignored until IDLE; p0_rdata/p1_rdata SHALL hold until next read completes on that port.
REQ-023 DQ SHALL never be driven in IDLE or during any read state.

Reset
REQ-024 On reset assertion, immediately and asynchronously: state IDLE, sram_ADDR=0, all SRAM strobes 1, DQ high-Z, p0_ack=p1_ack=0, rdata=0, busy=0, last_grant=1, counter=0.
REQ-025 Reset mid-access SHALL abort with no ack; requester reissues after reset release.

Verification
REQ-026 p0 read addr 0x00010, SRAM model returns 0xBEEF: ACCESS cycles 1-2 OE_N=0, p0_ack cycle 3, p0_rdata=0xBEEF, p1_rdata unchanged.
REQ-027 p1 write addr 0xFFFFF, data 0x1234, be=10: WE_N=0 two cycles, UB_N=0, LB_N=1, DQ=0x1234 through DONE; read-back gives 0x12 high byte, low byte prior value.
REQ-028 p0 and p1 raised same cycle from reset: p0 served first, p1 next; both held continuously -> grants alternate 0,1,0,1 every 4 cycles.
REQ-029 Reset asserted during p1 write ACCESS cycle 1: WE_N/CE_N go 1 and DQ high-Z without clock edge, no p1_ack; after release p1 reissue completes normally.
REQ-030 ACCESS_CYCLES=1 and =15: ack at cycle 2 and 16 after grant; p1_be=00 write acks with no byte strobe asserted; DQ never driven in any read.
